dmem_responder: RTL

- Data-memory responder serving the memory functional unit's load/store requests.
- Byte-addressable, word-organised synchronous RAM behind a valid/ready request channel and a single-cycle response pulse.
- Fixed, parameterised access latency; performs byte/half/word sub-word merging and sign/zero extension.
- Sits between the memory FU issue logic and the writeback/finish path of the scoreboard pipeline.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/dmem_lane_fmt.sv | 56 +++++
 rtl/dmem_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM states, lane count and the latched request bundle.
package mem_pkg;

  localparam logic [2:0] BHW_B  = 3'b000;
  localparam logic [2:0] BHW_H  = 3'b001;
  localparam logic [2:0] BHW_W  = 3'b010;
  localparam logic [2:0] BHW_BU = 3'b100;
  localparam logic [2:0] BHW_HU = 3'b101;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  bhw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Sub-word formatting: store byte enables / lane replication and load lane
// extraction with sign/zero extension. DMEM_MISALIGN_CHECK_EN enables error reporting.
module dmem_lane_fmt
  import mem_pkg::*;
(
  input  logic [2:0]       bhw,
  input  logic [1:0]       addr_lo,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rword,
  output logic [LANES-1:0] be,
  output logic [31:0]      wlanes,
  output logic [31:0]      rdata,
  output logic             err
);

  logic       is_b;
  logic       is_h;
  logic [1:0] off;
  logic [15:0] shifted;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    is_b    = (bhw == BHW_B) || (bhw == BHW_BU);
    is_h    = (bhw == BHW_H) || (bhw == BHW_HU);
    off     = addr_lo;
    err     = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    err = !(is_b || is_h || bhw == BHW_W)
          || (is_h && addr_lo[0])
          || (!is_b && !is_h && addr_lo != 2'b00);
`else
    // Without checking, the offset is forced to the access size; illegal codes act as words.
    if (is_h)       off = {addr_lo[1], 1'b0};
    else if (!is_b) off = 2'b00;
`endif
    shifted = 16'(rword >> {off, 3'b000});

    if (is_b)      be = 4'b0001 << off;
    else if (is_h) be = 4'b0011 << off;
    else           be = 4'b1111;

    if (is_b)      wlanes = {4{wdata[7:0]}};
    else if (is_h) wlanes = {2{wdata[15:0]}};
    else           wlanes = wdata;

    if (is_b)      rdata = bhw[2] ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
    else if (is_h) rdata = bhw[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    else           rdata = rword;

    if (err) begin
      be    = '0;
      rdata = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: valid/ready request in, one-cycle response pulse out.
// Optional misalignment/illegal-size errors under DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_bhw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [3:0] CNT_LAST = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

  state_t                  state, state_next;
  req_t                    req_q, op;
  logic [3:0]              cnt;
  logic                    commit;
  logic [31:0]             mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]   idx;
  logic [LANES-1:0]        be;
  logic [31:0]             wlanes;
  logic [31:0]             fmt_rdata;
  logic                    fmt_err;
  logic                    unused_op_addr;

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (LATENCY == 1) ? RESP : BUSY;
      end
      BUSY:    if (cnt == CNT_LAST) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is the accept edge, so the live request is used.
  assign op             = (state == IDLE) ? {req_we, req_bhw, req_addr, req_wdata} : req_q;
  assign commit         = (state_next == RESP);
  assign idx            = op.addr[ADDR_WIDTH+1:2];
  assign unused_op_addr = ^op.addr[31:ADDR_WIDTH+2];

  dmem_lane_fmt u_fmt (
    .bhw     (op.bhw),
    .addr_lo (op.addr[1:0]),
    .wdata   (op.wdata),
    .rword   (mem[idx]),
    .be      (be),
    .wlanes  (wlanes),
    .rdata   (fmt_rdata),
    .err     (fmt_err)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q      <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= commit;
      if (state == IDLE && req_valid) begin
        req_q <= op;
        cnt   <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 4'd1;
      end
      if (commit) begin
        resp_rdata <= op.we ? '0 : fmt_rdata;
        resp_err   <= fmt_err;
      end
    end
  end

  // NOTE: the RAM array has no reset; gating on rst_n keeps aborted stores from landing.
  always_ff @(posedge clk) begin
    if (rst_n && commit && op.we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

endmodule
